sdhci_rsp_receiver: RTL and testbench

Command-line response receiver for the SDHCI controller. It sits directly downstream of the CMD-line pin (`sd_cmd_i`) and upstream of the command sequencer and Auto CMD12 logic. Once the command transmitter has sent a command's end bit, the block is armed. It then:
- waits for the card's start bit,
- deserialises a 48-bit or 136-bit response,
- checks CRC7, end bit and command index,
- reports the payload and error flags with a single-cycle completion pulse.

---
 rtl/sdhci_rsp_receiver.sv | 156 +++++++++++++++
 tb/tb_sdhci_rsp_receiver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdhci_rsp_receiver.sv
// CMD-line response receiver: waits for a start bit, deserialises a 48/136-bit
// response, checks CRC7, end bit and index, and pulses done_o once.
module sdhci_rsp_receiver #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_clk_en_i,
    input  logic         sd_cmd_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         long_rsp_i,
    input  logic         check_crc_i,
    input  logic         check_index_i,
    input  logic [5:0]   expected_index_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         err_end_bit_o,
    output logic         err_index_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [135:0]    sr;
    logic [7:0]      bit_cnt;
    logic [CntW-1:0] to_cnt;
    logic [6:0]      crc;
    logic            crc_bad;
    logic            long_q;
    logic            check_crc_q;
    logic            check_index_q;
    logic [5:0]      exp_idx_q;

    logic [7:0]      bit_num;
    logic [7:0]      frame_len;
    logic            in_crc;
    logic            in_cmp;
    logic [6:0]      crc_next;
    logic            unused_sr_msb;

    // Bit number (1-based) of the bit being sampled on this strobe
    assign bit_num   = bit_cnt + 8'd1;
    assign frame_len = long_q ? 8'd136 : 8'd48;
    assign in_crc    = long_q ? (bit_num >= 8'd9 && bit_num <= 8'd128) : (bit_num <= 8'd40);
    assign in_cmp    = long_q ? (bit_num >= 8'd129 && bit_num <= 8'd135)
                              : (bit_num >= 8'd41 && bit_num <= 8'd47);
    assign crc_next  = {crc[5:0], 1'b0} ^ ({7{sd_cmd_i ^ crc[6]}} & 7'h09);

    // Payload and index are sliced straight out of the shift register
    assign rsp_o       = long_q ? sr[127:8] : {88'd0, sr[39:8]};
    assign rsp_index_o = long_q ? sr[133:128] : sr[45:40];
    assign unused_sr_msb = sr[135];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
            crc           <= '0;
            crc_bad       <= 1'b0;
            long_q        <= 1'b0;
            check_crc_q   <= 1'b0;
            check_index_q <= 1'b0;
            exp_idx_q     <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            err_crc_o     <= 1'b0;
            err_end_bit_o <= 1'b0;
            err_index_o   <= 1'b0;
        end else if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        long_q        <= long_rsp_i;
                        check_crc_q   <= check_crc_i;
                        check_index_q <= check_index_i;
                        exp_idx_q     <= expected_index_i;
                        sr            <= '0;
                        bit_cnt       <= '0;
                        to_cnt        <= '0;
                        crc           <= '0;
                        crc_bad       <= 1'b0;
                        err_timeout_o <= 1'b0;
                        err_crc_o     <= 1'b0;
                        err_end_bit_o <= 1'b0;
                        err_index_o   <= 1'b0;
                        busy_o        <= 1'b1;
                        state         <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (sd_clk_en_i) begin
                        if (!sd_cmd_i) begin
                            // Start bit is zero, so shifting it into a zero CRC leaves it zero
                            sr      <= {sr[134:0], 1'b0};
                            bit_cnt <= 8'd1;
                            crc     <= '0;
                            crc_bad <= 1'b0;
                            state   <= ST_RECEIVE;
                        end else if (to_cnt == CntW'(TimeoutCycles - 1)) begin
                            err_timeout_o <= 1'b1;
                            done_o        <= 1'b1;
                            busy_o        <= 1'b0;
                            state         <= ST_DONE;
                        end else begin
                            to_cnt <= to_cnt + CntW'(1);
                        end
                    end
                end
                ST_RECEIVE: begin
                    if (sd_clk_en_i) begin
                        sr      <= {sr[134:0], sd_cmd_i};
                        bit_cnt <= bit_num;
                        if (in_crc) begin
                            crc <= crc_next;
                        end else if (in_cmp) begin
                            crc <= {crc[5:0], 1'b0};
                            if (sd_cmd_i != crc[6]) crc_bad <= 1'b1;
                        end
                        if (bit_num == frame_len) begin
                            // Index field sits one position lower until the end bit is shifted in
                            err_end_bit_o <= ~sd_cmd_i;
                            err_crc_o     <= check_crc_q & crc_bad;
                            err_index_o   <= ~long_q & check_index_q & (sr[44:39] != exp_idx_q);
                            done_o        <= 1'b1;
                            busy_o        <= 1'b0;
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdhci_rsp_receiver.sv
// Self-checking bench for sdhci_rsp_receiver: directed vector table, corner
// sequences and randomized frames checked against a polynomial-division CRC model.
module tb_sdhci_rsp_receiver;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         sd_clk_en_i = 1'b0;
    logic         sd_cmd_i = 1'b1;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         long_rsp_i = 1'b0;
    logic         check_crc_i = 1'b0;
    logic         check_index_i = 1'b0;
    logic [5:0]   expected_index_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [119:0] rsp_o;
    logic [5:0]   rsp_index_o;
    logic         err_timeout_o;
    logic         err_crc_o;
    logic         err_end_bit_o;
    logic         err_index_o;

    int checks = 0;
    int errors = 0;

    sdhci_rsp_receiver #(.TimeoutCycles(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .sd_clk_en_i      (sd_clk_en_i),
        .sd_cmd_i         (sd_cmd_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .long_rsp_i       (long_rsp_i),
        .check_crc_i      (check_crc_i),
        .check_index_i    (check_index_i),
        .expected_index_i (expected_index_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .rsp_o            (rsp_o),
        .rsp_index_o      (rsp_index_o),
        .err_timeout_o    (err_timeout_o),
        .err_crc_o        (err_crc_o),
        .err_end_bit_o    (err_end_bit_o),
        .err_index_o      (err_index_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        trans;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        endb;
        logic [5:0]  exp_idx;
        logic        chk_crc;
        logic        chk_idx;
        int          period;
        logic        e_crc;
        logic        e_end;
        logic        e_idx;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1
    function automatic logic [6:0] crc7_model(input logic [119:0] msg, input int nbits);
        logic [126:0] v;
        v = 127'(msg) << 7;
        for (int i = nbits + 6; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    task automatic strobe(input logic b, input int period);
        for (int k = 1; k < period; k++) begin
            sd_clk_en_i = 1'b0;
            @(negedge clk_i);
        end
        sd_clk_en_i = 1'b1;
        sd_cmd_i    = b;
        @(negedge clk_i);
        sd_clk_en_i = 1'b0;
        sd_cmd_i    = 1'b1;
    endtask

    task automatic arm(input logic lng, input logic cc, input logic ci, input logic [5:0] ei);
        start_i          = 1'b1;
        long_rsp_i       = lng;
        check_crc_i      = cc;
        check_index_i    = ci;
        expected_index_i = ei;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", 120'(busy_o), 120'(1));
    endtask

    // Sends the top cnt bits of an n-bit frame; flags any done_o seen on the way
    task automatic send_bits(input logic [135:0] fr, input int n, input int cnt,
                             input int period, output logic early);
        early = 1'b0;
        for (int i = n - 1; i >= n - cnt; i--) begin
            if (done_o) early = 1'b1;
            strobe(fr[i], period);
        end
    endtask

    task automatic run_frame(input string name, input logic [135:0] fr, input logic lng,
                             input logic cc, input logic ci, input logic [5:0] ei,
                             input int period, input int pre, input logic [119:0] e_rsp,
                             input logic chk_index_field, input logic [5:0] e_index,
                             input logic e_crc, input logic e_end, input logic e_idx);
        int   n;
        logic early;
        logic [3:0] flags;
        n = lng ? 136 : 48;
        arm(lng, cc, ci, ei);
        for (int p = 0; p < pre; p++) strobe(1'b1, period);
        send_bits(fr, n, n - 1, period, early);
        chk({name, "_no_early_done"}, 120'(early | done_o), 120'(0));
        strobe(fr[0], period);
        chk({name, "_done"}, 120'(done_o), 120'(1));
        chk({name, "_rsp"}, rsp_o, e_rsp);
        if (chk_index_field) chk({name, "_index"}, 120'(rsp_index_o), 120'(e_index));
        flags = {err_timeout_o, err_crc_o, err_end_bit_o, err_index_o};
        chk({name, "_errs"}, 120'(flags), 120'({1'b0, e_crc, e_end, e_idx}));
        @(negedge clk_i);
        chk({name, "_single_pulse"}, 120'({done_o, busy_o}), 120'(0));
        chk({name, "_hold"}, 120'({err_timeout_o, err_crc_o, err_end_bit_o, err_index_o}),
            120'(flags));
    endtask

    task automatic run_vec(input string name, input vec_t v, input int pre);
        logic [39:0]  hdr;
        logic [135:0] fr;
        hdr = {1'b0, v.trans, v.idx, v.arg};
        fr  = 136'({hdr, v.crc, v.endb});
        run_frame(name, fr, 1'b0, v.chk_crc, v.chk_idx, v.exp_idx, v.period, pre,
                  120'(v.arg), 1'b1, v.idx, v.e_crc, v.e_end, v.e_idx);
    endtask

    function automatic logic [135:0] long_frame(input logic [119:0] pl, input logic [6:0] flip);
        return {2'b00, 6'h3F, pl, crc7_model(pl, 120) ^ flip, 1'b1};
    endfunction

    task automatic no_done_window(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) seen = 1'b1;
            @(negedge clk_i);
        end
        chk({name, "_no_done"}, 120'({seen, busy_o}), 120'(0));
    endtask

    initial begin
        logic         early;
        logic [119:0] pl;
        logic [135:0] fr;
        vec_t         v;

        tbl[0] = '{1'b0, 6'd12, 32'd0, 7'h7A, 1'b1, 6'd12, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 6'd0,  32'd0, 7'h00, 1'b1, 6'd0,  1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 6'd0,  32'd0, 7'h00, 1'b1, 6'd0,  1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 6'h3F, 32'd0, 7'h7F, 1'b1, 6'd12, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 6'd12, 32'd0, 7'h7A, 1'b0, 6'd12, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 6'h3F, 32'd0, 7'h7F, 1'b1, 6'd12, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_ctrl", 120'({busy_o, done_o}), 120'(0));
        chk("reset_rsp", rsp_o, 120'(0));
        chk("reset_index", 120'(rsp_index_o), 120'(0));
        chk("reset_errs", 120'({err_timeout_o, err_crc_o, err_end_bit_o, err_index_o}), 120'(0));

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i], 2);

        // Timeout after exactly 64 idle strobes
        arm(1'b0, 1'b1, 1'b1, 6'd12);
        for (int s = 0; s < 63; s++) strobe(1'b1, 2);
        chk("timeout_not_early", 120'({done_o, err_timeout_o}), 120'(0));
        strobe(1'b1, 2);
        chk("timeout_done", 120'(done_o), 120'(1));
        chk("timeout_errs", 120'({err_timeout_o, err_crc_o, err_end_bit_o, err_index_o}),
            120'(4'b1000));
        @(negedge clk_i);
        chk("timeout_single_pulse", 120'(done_o), 120'(0));

        // Start bit on the 64th strobe beats the timeout
        run_vec("start_on_64th", tbl[0], 63);

        // Long response, clean and with one CRC bit flipped
        pl = 120'h0123456789ABCDEFFEDCBA98765432;
        run_frame("long_ok", long_frame(pl, 7'h00), 1'b1, 1'b1, 1'b1, 6'd5, 2, 1, pl,
                  1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        run_frame("long_badcrc", long_frame(pl, 7'h10), 1'b1, 1'b1, 1'b1, 6'd5, 1, 0, pl,
                  1'b0, 6'd0, 1'b1, 1'b0, 1'b0);

        // Reset at bit 20, then a clean frame
        fr = 136'({1'b0, 1'b0, 6'd12, 32'd0, 7'h7A, 1'b1});
        arm(1'b0, 1'b1, 1'b1, 6'd12);
        send_bits(fr, 48, 20, 1, early);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_mid_state", 120'({early, rsp_o[31:0], err_timeout_o, err_crc_o,
                                   err_end_bit_o, err_index_o}), 120'(0));
        no_done_window("rst_mid");
        run_vec("after_rst", tbl[0], 0);

        // Abort at bit 30, then a clean frame
        arm(1'b0, 1'b1, 1'b1, 6'd12);
        send_bits(fr, 48, 30, 2, early);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_early", 120'(early), 120'(0));
        no_done_window("abort_mid");
        run_vec("after_abort", tbl[1], 1);

        // Randomized short frames against the CRC model
        for (int r = 0; r < 30; r++) begin
            logic [6:0] good;
            logic [6:0] flip;
            v.trans   = 1'($urandom_range(0, 1));
            v.idx     = 6'($urandom);
            v.arg     = $urandom;
            good      = crc7_model(120'({1'b0, v.trans, v.idx, v.arg}), 40);
            flip      = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            v.crc     = good ^ flip;
            v.endb    = ($urandom_range(0, 4) != 0);
            v.exp_idx = ($urandom_range(0, 1) == 1) ? v.idx : 6'($urandom);
            v.chk_crc = 1'($urandom_range(0, 1));
            v.chk_idx = 1'($urandom_range(0, 1));
            v.period  = int'($urandom_range(1, 4));
            v.e_crc   = v.chk_crc && (v.crc != good);
            v.e_end   = !v.endb;
            v.e_idx   = v.chk_idx && (v.idx != v.exp_idx);
            run_vec($sformatf("rand%0d", r), v, int'($urandom_range(0, 8)));
        end

        // Randomized long frames
        for (int r = 0; r < 4; r++) begin
            logic [6:0] flip;
            logic       cc;
            pl   = {$urandom, $urandom, $urandom, 24'($urandom)};
            flip = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
            cc   = 1'($urandom_range(0, 1));
            run_frame($sformatf("rlong%0d", r), long_frame(pl, flip), 1'b1, cc, 1'b1,
                      6'($urandom), int'($urandom_range(1, 3)), 0, pl, 1'b0, 6'd0,
                      cc && (flip != 7'd0), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
